// File: rtl/dist_seq_ctrl.sv
// rtl/dist_seq_ctrl.sv - sequencer for a lane-parallel accumulate + square-root vector norm pipeline
// Each vector is split into steps of LANES elements; the final step hands off to the sqrt unit.
module dist_seq_ctrl #(
    parameter int CNT_W = 8,
    parameter int LANES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic [CNT_W-1:0] num_vectors,
    input  logic [CNT_W-1:0] vector_width,
    input  logic             acc_rdy,
    input  logic             sqrt_rdy,
    output logic             acc_en,
    output logic             acc_rst,
    output logic             acc_pre,
    output logic             sqrt_en,
    output logic [CNT_W-1:0] elem_idx,
    output logic [CNT_W-1:0] vec_idx,
    output logic             busy,
    output logic             vec_done,
    output logic             done,
    output logic             err
);

    typedef enum logic [2:0] {
        IDLE,
        HARD_RST,
        WAIT_ACC,
        SOFT_RST,
        WAIT_SQRT
    } state_t;

    localparam logic [CNT_W:0] LANES_W = (CNT_W + 1)'(LANES);

    state_t           state, state_d;
    logic [CNT_W-1:0] elem_q, elem_d, vec_q, vec_d, nv_q, nv_d, vw_q, vw_d;
    logic             vec_done_d, done_d, err_d;
    logic [CNT_W:0]   next_elem;
    logic             last_step;

    // One extra bit so the end-of-vector test never wraps near 2^CNT_W.
    assign next_elem = {1'b0, elem_q} + LANES_W;
    assign last_step = next_elem >= {1'b0, vw_q};

    assign elem_idx = elem_q;
    assign vec_idx  = vec_q;
    assign busy     = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            elem_q   <= '0;
            vec_q    <= '0;
            nv_q     <= '0;
            vw_q     <= '0;
            vec_done <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
        end else begin
            state    <= state_d;
            elem_q   <= elem_d;
            vec_q    <= vec_d;
            nv_q     <= nv_d;
            vw_q     <= vw_d;
            vec_done <= vec_done_d;
            done     <= done_d;
            err      <= err_d;
        end
    end

    always_comb begin
        state_d    = state;
        elem_d     = elem_q;
        vec_d      = vec_q;
        nv_d       = nv_q;
        vw_d       = vw_q;
        vec_done_d = 1'b0;
        done_d     = 1'b0;
        err_d      = 1'b0;
        acc_en     = 1'b0;
        acc_rst    = 1'b0;
        acc_pre    = 1'b0;
        sqrt_en    = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    if (num_vectors == '0 || vector_width == '0) begin
                        err_d  = 1'b1;
                        done_d = 1'b1;
                    end else begin
                        nv_d    = num_vectors;
                        vw_d    = vector_width;
                        elem_d  = '0;
                        vec_d   = '0;
                        state_d = HARD_RST;
                    end
                end
            end
            HARD_RST: begin
                acc_en  = 1'b1;
                acc_rst = 1'b1;
                state_d = WAIT_ACC;
            end
            WAIT_ACC: begin
                acc_en = 1'b1;
                if (acc_rdy) begin
                    if (last_step) begin
                        state_d = WAIT_SQRT;
                    end else begin
                        elem_d  = next_elem[CNT_W-1:0];
                        state_d = SOFT_RST;
                    end
                end
            end
            SOFT_RST: begin
                acc_en  = 1'b1;
                acc_rst = 1'b1;
                acc_pre = 1'b1;
                state_d = WAIT_ACC;
            end
            WAIT_SQRT: begin
                acc_en  = 1'b1;
                sqrt_en = 1'b1;
                if (sqrt_rdy) begin
                    vec_done_d = 1'b1;
                    if (vec_q == nv_q - CNT_W'(1)) begin
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        vec_d   = vec_q + CNT_W'(1);
                        elem_d  = '0;
                        state_d = HARD_RST;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        // Abort overrides any handshake taken above in the same cycle.
        if (state != IDLE && abort) begin
            state_d    = IDLE;
            elem_d     = elem_q;
            vec_d      = vec_q;
            vec_done_d = 1'b0;
            done_d     = 1'b0;
        end
    end

endmodule

// File: tb/tb_dist_seq_ctrl.sv
// tb/tb_dist_seq_ctrl.sv - randomized and directed bench for dist_seq_ctrl with a step-level reference model
module tb_dist_seq_ctrl;
    localparam int CNT_W = 8;
    localparam int LANES = 4;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0, abort = 1'b0, acc_rdy = 1'b0, sqrt_rdy = 1'b0;
    logic [CNT_W-1:0] num_vectors = '0, vector_width = '0;
    logic             acc_en, acc_rst, acc_pre, sqrt_en, busy, vec_done, done, err;
    logic [CNT_W-1:0] elem_idx, vec_idx;

    dist_seq_ctrl #(.CNT_W(CNT_W), .LANES(LANES)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .num_vectors(num_vectors), .vector_width(vector_width),
        .acc_rdy(acc_rdy), .sqrt_rdy(sqrt_rdy),
        .acc_en(acc_en), .acc_rst(acc_rst), .acc_pre(acc_pre), .sqrt_en(sqrt_en),
        .elem_idx(elem_idx), .vec_idx(vec_idx), .busy(busy),
        .vec_done(vec_done), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    int n_cmp = 0, n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a run is a list of vectors, each a list of ceil(width/LANES) steps.
    // m_phase: 0 = first-step strobe, 1 = later-step strobe, 2 = waiting on accumulator, 3 = waiting on sqrt
    bit m_busy, m_zero, m_vdone, m_done, m_err;
    int m_phase, m_step, m_vec, m_nv, m_vw;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy <= 0; m_zero <= 1; m_vdone <= 0; m_done <= 0; m_err <= 0;
            m_phase <= 0; m_step <= 0; m_vec <= 0; m_nv <= 0; m_vw <= 0;
        end else begin
            m_vdone <= 0; m_done <= 0; m_err <= 0;
            if (!m_busy) begin
                if (start) begin
                    if (num_vectors == 0 || vector_width == 0) begin
                        m_err <= 1; m_done <= 1;
                    end else begin
                        m_busy <= 1; m_zero <= 0; m_nv <= int'(num_vectors); m_vw <= int'(vector_width);
                        m_vec <= 0; m_step <= 0; m_phase <= 0;
                    end
                end
            end else if (abort) begin
                m_busy <= 0;
            end else begin
                case (m_phase)
                    0, 1: m_phase <= 2;
                    2: if (acc_rdy) begin
                        if (m_step == (m_vw + LANES - 1) / LANES - 1) m_phase <= 3;
                        else begin m_step <= m_step + 1; m_phase <= 1; end
                    end
                    default: if (sqrt_rdy) begin
                        m_vdone <= 1;
                        if (m_vec == m_nv - 1) begin m_done <= 1; m_busy <= 0; end
                        else begin m_vec <= m_vec + 1; m_step <= 0; m_phase <= 0; end
                    end
                endcase
            end
        end
    end

    always @(negedge clk) begin
        check("busy", busy, m_busy);
        check("acc_en", acc_en, m_busy);
        check("acc_rst", acc_rst, m_busy && m_phase <= 1);
        check("acc_pre", acc_pre, m_busy && m_phase == 1);
        check("sqrt_en", sqrt_en, m_busy && m_phase == 3);
        check("vec_done", vec_done, m_vdone);
        check("done", done, m_done);
        check("err", err, m_err);
        if (m_busy || m_zero) begin
            check("elem_idx", elem_idx, m_busy ? m_step * LANES : 0);
            check("vec_idx", vec_idx, m_busy ? m_vec : 0);
        end
    end

    // mode 0: inputs held by the main thread, 1: timed responder, 2: fully random
    int mode = 0, ac = 0, sc = 0;
    bit stress = 0;
    int n_hard, n_soft, n_vdone, n_done, n_err, n_busy, n_accen, n_sqrt, n_both, max_elem;

    task automatic clr();
        n_hard = 0; n_soft = 0; n_vdone = 0; n_done = 0; n_err = 0;
        n_busy = 0; n_accen = 0; n_sqrt = 0; n_both = 0; max_elem = 0;
    endtask

    task automatic step();
        @(negedge clk);
        #1;
        if (acc_rst) ac = 0; else if (acc_en && !sqrt_en) ac++;
        if (sqrt_en) sc++; else sc = 0;
        if (acc_rst && !acc_pre) n_hard++;
        if (acc_rst && acc_pre) n_soft++;
        if (vec_done) n_vdone++;
        if (done) n_done++;
        if (err) n_err++;
        if (busy) n_busy++;
        if (acc_en) n_accen++;
        if (sqrt_en) n_sqrt++;
        if (done && vec_done) n_both++;
        if (busy && int'(elem_idx) > max_elem) max_elem = int'(elem_idx);
        if (mode == 1) begin
            acc_rdy  = acc_en && !acc_rst && !sqrt_en && ac == 3;
            sqrt_rdy = (sc == 2);
            if (busy) begin num_vectors = CNT_W'($urandom); vector_width = CNT_W'($urandom); end
            if (stress) start = acc_rdy;
        end else if (mode == 2) begin
            start        = ($urandom % 6 == 0);
            abort        = ($urandom % 30 == 0);
            acc_rdy      = ($urandom % 3 == 0);
            sqrt_rdy     = ($urandom % 3 == 0);
            num_vectors  = CNT_W'($urandom % 4);
            vector_width = CNT_W'($urandom % 14);
        end
    endtask

    task automatic run_auto(input int nv, input int vw, input int limit);
        bit got;
        mode = 1; num_vectors = CNT_W'(nv); vector_width = CNT_W'(vw);
        start = 1;
        step();
        start = 0;
        check("start_to_hard_rst", {acc_rst, acc_pre, busy}, 3'b101);
        got = 0;
        for (int i = 0; i < limit && !got; i++) begin
            step();
            if (done) got = 1;
        end
        check("run_completes", got, 1);
    endtask

    initial begin
        clr();
        repeat (2) step();
        rst_n = 1;
        step();
        check("rst_busy", busy, 0);
        check("rst_idx", {elem_idx, vec_idx}, 0);
        check("rst_strobes", {acc_en, acc_rst, acc_pre, sqrt_en}, 0);

        // 2 vectors x 10 elements: steps at 0,4,8
        clr(); run_auto(2, 10, 200);
        check("w10_hard", n_hard, 2);
        check("w10_soft", n_soft, 4);
        check("w10_vdone", n_vdone, 2);
        check("w10_done_with_vdone", n_both, 1);
        check("w10_last_elem", max_elem, 8);

        clr(); run_auto(1, 4, 100);
        check("w4_hard", n_hard, 1);
        check("w4_soft", n_soft, 0);
        check("w4_vdone", n_vdone, 1);

        clr(); run_auto(1, 255, 2000);
        check("w255_steps", n_hard + n_soft, 64);
        check("w255_last_elem", max_elem, 252);
        check("w255_sqrt_cycles", n_sqrt, 2);

        clr(); mode = 0; num_vectors = 0; vector_width = 5; start = 1;
        step(); start = 0;
        repeat (4) step();
        check("nv0_err", n_err, 1);
        check("nv0_done", n_done, 1);
        check("nv0_busy", n_busy, 0);
        check("nv0_acc_en", n_accen, 0);

        // abort coinciding with sqrt_rdy on the first of three vectors
        clr(); mode = 1; num_vectors = 3; vector_width = 6; start = 1;
        step(); start = 0;
        for (int i = 0; i < 100 && !sqrt_rdy; i++) step();
        check("abort_reached_sqrt", {sqrt_rdy, vec_idx}, 9'h100);
        abort = 1; mode = 0;
        step();
        abort = 0; sqrt_rdy = 0; acc_rdy = 0;
        check("abort_idle", busy, 0);
        repeat (3) step();
        check("abort_no_vdone", n_vdone, 0);
        check("abort_no_done", n_done, 0);
        clr(); run_auto(3, 6, 300);
        check("after_abort_vdone", n_vdone, 3);

        // asynchronous reset in the middle of WAIT_ACC
        clr(); mode = 1; num_vectors = 2; vector_width = 9; start = 1;
        step(); start = 0;
        for (int i = 0; i < 50 && !(acc_en && !acc_rst && !sqrt_en); i++) step();
        #2 rst_n = 0;
        #1 check("async_rst_outputs", {acc_en, acc_rst, acc_pre, sqrt_en, busy, elem_idx, vec_idx}, 0);
        step(); rst_n = 1;
        repeat (4) step();
        check("no_resume", busy, 0);

        clr(); stress = 1; run_auto(2, 9, 400); stress = 0;
        check("stress_vdone", n_vdone, 2);
        check("stress_steps", n_hard + n_soft, 6);

        mode = 2;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom % 400 == 0) begin rst_n = 0; step(); rst_n = 1; end
            step();
        end
        mode = 0; start = 0; abort = 0; acc_rdy = 0; sqrt_rdy = 0;
        repeat (2) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
